dmem_lsu_ctrl: RTL
==================

# dmem_lsu_ctrl

Parametrised load/store controller between the core's EXE/MEM stage and the data-memory port, using a req/gnt/rvalid handshake. It replaces the flat combinational data-memory wrapper with a tracked transaction: it holds the core stalled until the response arrives, generates byte enables and lane-aligned write data for sub-word accesses, and sign- or zero-extends load data. It also flags misaligned accesses, bus errors and response timeouts.

## Interface
- DATA_W, 32: bus data width, 32 or 64; BE_W = DATA_W/8, OFF_W = log2(BE_W)
- ADDR_W, 32: address width
- TIMEOUT_CYC, 255: cycles allowed in each wait state before abort (≥1)
- ERR_PATTERN, 32'hbabecafe: value driven on o_data_rdata when no valid load data (replicated to DATA_W)
- clk_i  in  1  clock, all logic rising-edge
- rst_i  in  1  synchronous, active-high reset
- i_exe_mem2reg  in  1  load request; held stable while o_stall=1
- i_exe_wmem  in  1  store request; held stable while o_stall=1
- i_data_addr  in  ADDR_W  byte address
- i_data_wdata  in  DATA_W  store data, LSB-justified
- i_data_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only for DATA_W=64)
- i_data_sext  in  1  1 = sign-extend load result
- data_gnt_i / data_rvalid_i / data_err_i  in  1 each  memory grant, response valid, response error
- data_rdata_i  in  DATA_W  read data
- data_rdata_intg_i  in  7  ignored
- data_req_o / data_we_o  out  1 each  request, write enable
- data_be_o  out  BE_W  byte enables
- data_addr_o  out  ADDR_W  address; low OFF_W bits forced to 0
- data_wdata_o  out  DATA_W  lane-aligned store data
- data_wdata_intg_o  out  7  tied to 0
- o_data_rdata  out  DATA_W  formatted load data
- o_stall  out  1  core must hold EXE/MEM
- o_misaligned  out  1  one-cycle pulse, access rejected
- o_data_err  out  1  one-cycle pulse, bus error or timeout

## Operation
- Core request = i_exe_mem2reg | i_exe_wmem. Both set means store.
- Alignment:
  - Half requires addr[0]=0. Word requires addr[1:0]=0. Dword requires addr[2:0]=0.
  - Size 11 with DATA_W=32 is illegal.
  - Any violation: no bus request, o_misaligned=1 for the request cycle, o_stall=0.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
  - IDLE with legal request: data_req_o=1 combinationally. With gnt → WAIT_RVALID, otherwise → WAIT_GNT.
  - WAIT_GNT: data_req_o=1 and all address/data/be outputs held from captured registers. On gnt → WAIT_RVALID.
  - WAIT_RVALID: data_req_o=0. On rvalid → IDLE.
- Captured at issue: offset = addr[OFF_W-1:0], size, sext, we, addr, wdata, be.
- data_be_o: byte ((1<<1)-1)<<off; half 2'b11<<off; word 4'hF<<off; dword all ones.
- data_wdata_o = i_data_wdata << (8*off).
- Load result = (data_rdata_i >> 8*off), truncated to size, then sign- or zero-extended to DATA_W.
- Store responses also complete on rvalid; o_data_rdata = ERR_PATTERN for them.
- o_data_rdata = formatted data only in the rvalid cycle of an error-free load. ERR_PATTERN otherwise.
- Bus error: data_err_i with rvalid → o_data_err=1, o_data_rdata=ERR_PATTERN, return to IDLE.
- Timeout counter:
  - Clears on every state entry and increments each cycle in WAIT_GNT/WAIT_RVALID.
  - When count reaches TIMEOUT_CYC-1 without the exit event: o_data_err=1, o_stall=0, → IDLE.
  - In WAIT_GNT, data_req_o is dropped after the abort.
- rvalid in IDLE (stray or post-timeout) is ignored; no outputs change.
- o_stall = (IDLE & legal request & !(gnt & 0)) | WAIT_GNT | WAIT_RVALID, deasserted in the completing cycle (rvalid or timeout). A request is never completed in the cycle it is issued.

## Timing
- Reset values: state IDLE, counter 0. data_req_o=0, data_we_o=0, data_be_o=0, o_stall=0, o_misaligned=0, o_data_err=0, o_data_rdata=ERR_PATTERN.
- Reset mid-transaction: IDLE on the next edge, data_req_o=0 from that cycle; the pending response is discarded.
- Minimum latency: issue with gnt in cycle N, rvalid in N+1 → data valid and o_stall=0 in N+1.
- o_stall is high for cycle N.
- Memory must give rvalid ≥1 cycle after gnt. gnt and rvalid for the same transaction never coincide.
- Back-to-back: a new request may be issued in the IDLE cycle directly after completion.

## Test plan
- Word load, addr 0x100, gnt same cycle, rvalid +1 with 0xDEADBEEF → be=4'hF, stall 1 cycle, o_data_rdata=0xDEADBEEF.
- Byte load, sext=1, addr 0x103, rdata 0x80FFFFFF → be=4'b1000, o_data_rdata=0xFFFFFF80. With sext=0 → 0x00000080.
- Half store, addr 0x202, wdata 0x0000ABCD, gnt delayed 3 cycles → req held 4 cycles, be=4'b1100, wdata_o=0xABCD0000, addr/be stable throughout.
- Word load at 0x101 → no req, o_misaligned 1 cycle, stall 0.
- No rvalid for TIMEOUT_CYC cycles → o_data_err pulse, stall drops, FSM IDLE, a late rvalid is ignored. data_err_i with rvalid → o_data_err, rdata=0xbabecafe.
- rst_i asserted in WAIT_GNT → req 0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: tracked load/store controller between the EXE/MEM stage and
// a req/gnt/rvalid data-memory port. Stalls the core until the response (or a
// timeout) completes the access, lane-aligns sub-word stores, formats loads
// and rejects misaligned accesses without touching the bus.
module dmem_lsu_ctrl #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_PATTERN = 32'hbabecafe
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_exe_mem2reg,
    input  logic                  i_exe_wmem,
    input  logic [ADDR_W-1:0]     i_data_addr,
    input  logic [DATA_W-1:0]     i_data_wdata,
    input  logic [1:0]            i_data_size,
    input  logic                  i_data_sext,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    input  logic                  data_err_i,
    input  logic [DATA_W-1:0]     data_rdata_i,
    input  logic [6:0]            data_rdata_intg_i,
    output logic                  data_req_o,
    output logic                  data_we_o,
    output logic [DATA_W/8-1:0]   data_be_o,
    output logic [ADDR_W-1:0]     data_addr_o,
    output logic [DATA_W-1:0]     data_wdata_o,
    output logic [6:0]            data_wdata_intg_o,
    output logic [DATA_W-1:0]     o_data_rdata,
    output logic                  o_stall,
    output logic                  o_misaligned,
    output logic                  o_data_err
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DATA_W-1:0] ERR_FILL = {(DATA_W/32){ERR_PATTERN}};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_GNT    = 2'd1,
        ST_WAIT_RVALID = 2'd2
    } state_e;

    // Natural alignment check; dword is only legal on a 64-bit bus.
    function automatic logic size_legal(input logic [1:0] size, input logic [2:0] low);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return (low[0] == 1'b0);
            2'b10:   return (low[1:0] == 2'b00);
            2'b11:   return (DATA_W == 64) && (low == 3'b000);
            default: return 1'b0;
        endcase
    endfunction

    // Byte-lane enables for an access of the given size at the given offset.
    function automatic logic [BE_W-1:0] byte_enables(input logic [1:0] size, input logic [OFF_W-1:0] off);
        case (size)
            2'b00:   return BE_W'(1'b1) << off;
            2'b01:   return BE_W'(2'b11) << off;
            2'b10:   return BE_W'(4'hF) << off;
            default: return {BE_W{1'b1}};
        endcase
    endfunction

    // Shift the addressed lane down, truncate to size, then sign/zero-extend.
    function automatic logic [DATA_W-1:0] format_load(input logic [DATA_W-1:0] rdata,
                                                       input logic [OFF_W-1:0]  off,
                                                       input logic [1:0]        size,
                                                       input logic              sext);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] mask;
        logic              sign;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b00:   begin mask = DATA_W'(8'hFF);         sign = sh[7];  end
            2'b01:   begin mask = DATA_W'(16'hFFFF);      sign = sh[15]; end
            2'b10:   begin mask = DATA_W'(32'hFFFF_FFFF); sign = sh[31]; end
            default: begin mask = {DATA_W{1'b1}};         sign = 1'b0;   end
        endcase
        return (sh & mask) | ({DATA_W{sext & sign}} & ~mask);
    endfunction

    state_e                   state_r;
    state_e                   state_nxt_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [OFF_W-1:0]         off_r;
    logic [1:0]               size_r;
    logic                     sext_r;
    logic                     we_r;
    logic [ADDR_W-OFF_W-1:0]  addr_r;
    logic [DATA_W-1:0]        wdata_r;
    logic [BE_W-1:0]          be_r;

    logic                     core_req_s;
    logic                     legal_s;
    logic                     issue_s;
    logic                     timeout_s;
    logic [OFF_W-1:0]         off_in_s;
    logic [BE_W-1:0]          be_in_s;
    logic [DATA_W-1:0]        wdata_in_s;
    logic                     unused_intg_s;

    assign core_req_s        = i_exe_mem2reg | i_exe_wmem;
    assign legal_s           = size_legal(i_data_size, i_data_addr[2:0]);
    assign issue_s           = (state_r == ST_IDLE) && core_req_s && legal_s;
    assign timeout_s         = (cnt_r == CNT_LAST);
    assign off_in_s          = i_data_addr[OFF_W-1:0];
    assign be_in_s           = byte_enables(i_data_size, off_in_s);
    assign wdata_in_s        = i_data_wdata << {off_in_s, 3'b000};
    assign data_wdata_intg_o = 7'd0;
    assign unused_intg_s     = ^data_rdata_intg_i;

    // Next-state and all bus/core outputs; IDLE drives the bus straight from the core.
    always_comb begin
        state_nxt_s  = state_r;
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_be_o    = {BE_W{1'b0}};
        data_addr_o  = {addr_r, {OFF_W{1'b0}}};
        data_wdata_o = wdata_r;
        o_stall      = 1'b0;
        o_misaligned = 1'b0;
        o_data_err   = 1'b0;
        o_data_rdata = ERR_FILL;
        if (rst_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    data_addr_o  = {i_data_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    data_wdata_o = wdata_in_s;
                    if (core_req_s) begin
                        if (legal_s) begin
                            data_req_o  = 1'b1;
                            data_we_o   = i_exe_wmem;
                            data_be_o   = be_in_s;
                            o_stall     = 1'b1;
                            state_nxt_s = data_gnt_i ? ST_WAIT_RVALID : ST_WAIT_GNT;
                        end else begin
                            o_misaligned = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT_GNT: begin
                    data_req_o = 1'b1;
                    data_we_o  = we_r;
                    data_be_o  = be_r;
                    if (data_gnt_i) begin
                        o_stall     = 1'b1;
                        state_nxt_s = ST_WAIT_RVALID;
                    end else if (timeout_s) begin
                        o_data_err  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        o_stall = 1'b1;
                    end
                end
                ST_WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        state_nxt_s = ST_IDLE;
                        if (data_err_i) begin
                            o_data_err = 1'b1;
                        end else if (!we_r) begin
                            o_data_rdata = format_load(data_rdata_i, off_r, size_r, sext_r);
                        end else begin
                            o_data_rdata = ERR_FILL;
                        end
                    end else if (timeout_s) begin
                        o_data_err  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        o_stall = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register and per-state timeout counter (cleared on every state entry).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if ((state_nxt_s != state_r) || (state_r == ST_IDLE)) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Capture the access attributes at issue so the bus stays stable while waiting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            off_r   <= {OFF_W{1'b0}};
            size_r  <= 2'b00;
            sext_r  <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= {(ADDR_W-OFF_W){1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            be_r    <= {BE_W{1'b0}};
        end else if (issue_s) begin
            off_r   <= off_in_s;
            size_r  <= i_data_size;
            sext_r  <= i_data_sext;
            we_r    <= i_exe_wmem;
            addr_r  <= i_data_addr[ADDR_W-1:OFF_W];
            wdata_r <= wdata_in_s;
            be_r    <= be_in_s;
        end
    end

endmodule
